lbp_stream: RTL and testbench

Parametrised streaming Local Binary Pattern engine, the next generation of the team's 128×128 LBP block. It reads each gray pixel exactly once, in raster order, through a single-cycle request/response port. Neighbourhoods are formed in internal line buffers, and one 8-bit LBP code per pixel is written to the result memory. Compared with the previous block it adds generic image size and pixel width, an optional threshold-offset mode, full-throughput streaming and ready-based stalling.

---
 rtl/lbp_stream_if.sv | 25 ++
 rtl/lbp_stream.sv | 201 ++++++++++++++++++++
 tb/tb_lbp_stream.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_stream_if.sv
// Request/response pixel port and result-write port of the streaming LBP engine.
interface lbp_stream_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;

  // Engine side
  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data
  );

  // Pixel source / result memory side
  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data
  );
endinterface

// File: rtl/lbp_stream.sv
// Streaming 3x3 Local Binary Pattern engine. Pixels are read once in raster
// order; a (2*IMG_W+3)-deep shift window supplies every neighbourhood. One
// 8-bit code per pixel is written in ascending address order, borders as 0.
module lbp_stream #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  lbp_stream_if.master  bus,
  input  logic          mode,
  input  logic [DW-1:0] thr,
  output logic          finish
);

  localparam int N  = IMG_W * IMG_H;
  localparam int WD = 2 * IMG_W + 3;
  localparam int XW = $clog2(IMG_W);

  localparam logic [AW:0] N_C   = (AW + 1)'(N);
  localparam logic [AW:0] LAST_C = (AW + 1)'(N - 1);
  localparam logic [AW:0] W1_C  = (AW + 1)'(IMG_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] thr_q, thr_d;
  logic [AW:0]   iss_q, iss_d;     // requests issued so far
  logic [AW:0]   samp_q, samp_d;   // index of the next pixel to be sampled
  logic [AW:0]   cen_q, cen_d;     // next center address to emit
  logic          emit_q, emit_d;   // a center is ready to be coded next edge
  logic [AW-1:0] emit_addr_q, emit_addr_d;
  logic          res_valid_q, res_valid_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic [7:0]    res_data_q, res_data_d;
  logic          finish_q, finish_d;
  logic [DW-1:0] window_q [WD];
  logic [DW-1:0] window_d [WD];

  logic [DW-1:0]   nb [8];
  logic [DW:0]     thr_eff;
  logic [7:0]      code;
  logic            border;
  logic [XW-1:0]   ex;
  logic [AW-XW-1:0] ey;

  assign bus.gray_req  = req_q;
  assign bus.gray_addr = addr_q;
  assign bus.lbp_valid = res_valid_q;
  assign bus.lbp_addr  = res_addr_q;
  assign bus.lbp_data  = res_data_q;
  assign finish        = finish_q;

  // LBP code of the pending center: window[0] is the newest pixel, so the
  // center sits at IMG_W+1 and each neighbour at a fixed tap.
  always_comb begin
    nb[0] = window_q[2*IMG_W+2];  // top-left
    nb[1] = window_q[2*IMG_W+1];  // top
    nb[2] = window_q[2*IMG_W];    // top-right
    nb[3] = window_q[IMG_W+2];    // left
    nb[4] = window_q[IMG_W];      // right
    nb[5] = window_q[2];          // bottom-left
    nb[6] = window_q[1];          // bottom
    nb[7] = window_q[0];          // bottom-right
    thr_eff = {1'b0, window_q[IMG_W+1]} + (mode_q ? {1'b0, thr_q} : '0);
    code = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      code[i] = ({1'b0, nb[i]} >= thr_eff);
    end
    ex = emit_addr_q[XW-1:0];
    ey = emit_addr_q[AW-1:XW];
    border = (ex == '0) || (ex == XW'(IMG_W - 1)) ||
             (ey == '0) || (ey == (AW - XW)'(IMG_H - 1));
  end

  // Sequencing: request issue, window shift, result emission and flush.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    iss_d       = iss_q;
    samp_d      = samp_q;
    cen_d       = cen_q;
    emit_d      = 1'b0;
    emit_addr_d = emit_addr_q;
    finish_d    = finish_q;
    window_d    = window_q;

    // Result stage always follows the emit stage by one edge.
    res_valid_d = emit_q;
    res_addr_d  = emit_q ? emit_addr_q : res_addr_q;
    res_data_d  = emit_q ? (border ? 8'h00 : code) : res_data_q;

    case (state_q)
      IDLE: begin
        if (bus.gray_ready) begin
          state_d = READ;
          req_d   = 1'b1;
          addr_d  = '0;
          iss_d   = (AW + 1)'(1);
          samp_d  = '0;
          cen_d   = '0;
          mode_d  = mode;
          thr_d   = thr;
        end
      end
      READ: begin
        if (bus.gray_ready && (iss_q < N_C)) begin
          req_d  = 1'b1;
          addr_d = iss_q[AW-1:0];
          iss_d  = iss_q + 1'b1;
        end else begin
          req_d  = 1'b0;
        end
        if (req_q) begin
          window_d[0] = bus.gray_data;
          for (int unsigned i = 1; i < WD; i++) begin
            window_d[i] = window_q[i-1];
          end
          samp_d = samp_q + 1'b1;
          if (samp_q >= W1_C) begin
            emit_d      = 1'b1;
            emit_addr_d = cen_q[AW-1:0];
            cen_d       = cen_q + 1'b1;
          end
          if (samp_q == LAST_C) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        req_d = 1'b0;
        if (cen_q < N_C) begin
          emit_d      = 1'b1;
          emit_addr_d = cen_q[AW-1:0];
          cen_d       = cen_q + 1'b1;
        end else if (!emit_q) begin
          // Wait until the last flush result has left the emit stage.
          state_d  = DONE;
          finish_d = 1'b1;
        end
      end
      default: begin
        req_d    = 1'b0;
        finish_d = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      mode_q      <= 1'b0;
      thr_q       <= '0;
      iss_q       <= '0;
      samp_q      <= '0;
      cen_q       <= '0;
      emit_q      <= 1'b0;
      emit_addr_q <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
      finish_q    <= 1'b0;
      for (int unsigned i = 0; i < WD; i++) begin
        window_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      iss_q       <= iss_d;
      samp_q      <= samp_d;
      cen_q       <= cen_d;
      emit_q      <= emit_d;
      emit_addr_q <= emit_addr_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
      finish_q    <= finish_d;
      for (int unsigned i = 0; i < WD; i++) begin
        window_q[i] <= window_d[i];
      end
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// Testbench for lbp_stream: a 128x128 and an 8x8 instance, driven one frame
// at a time from a shared image array; results captured into a memory model.
module tb_lbp_stream;
  localparam int BW = 128, BH = 128, BAW = 14;
  localparam int SW = 8,   SH = 8,   SAW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       mode_b, mode_s;
  logic [7:0] thr_b, thr_s;
  logic       fin_b, fin_s;

  lbp_stream_if #(.AW(BAW), .DW(8)) bif ();
  lbp_stream_if #(.AW(SAW), .DW(8)) sif ();

  logic [7:0] img [0:16383];
  assign bif.gray_data = img[bif.gray_addr];
  assign sif.gray_data = img[{8'd0, sif.gray_addr}];

  lbp_stream #(.IMG_W(BW), .IMG_H(BH), .AW(BAW), .DW(8)) u_big (
    .clk(clk), .reset(reset), .bus(bif), .mode(mode_b), .thr(thr_b), .finish(fin_b));
  lbp_stream #(.IMG_W(SW), .IMG_H(SH), .AW(SAW), .DW(8)) u_small (
    .clk(clk), .reset(reset), .bus(sif), .mode(mode_s), .thr(thr_s), .finish(fin_s));

  int checks = 0;
  int errors = 0;

  logic [7:0] mem  [0:16383];
  int         wcnt [0:16383];
  int         order_err;
  int         last_addr;

  function automatic void record(input int a, input logic [7:0] d);
    mem[a] = d;
    wcnt[a] = wcnt[a] + 1;
    if (a <= last_addr) order_err = order_err + 1;
    last_addr = a;
  endfunction

  // Result memory: written on the falling edge after lbp_valid.
  always @(negedge clk) begin
    if (bif.lbp_valid) record(int'(bif.lbp_addr), bif.lbp_data);
    if (sif.lbp_valid) record(int'(sif.lbp_addr), sif.lbp_data);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic cur_req(input bit big);
    return big ? bif.gray_req : sif.gray_req;
  endfunction
  function automatic logic cur_valid(input bit big);
    return big ? bif.lbp_valid : sif.lbp_valid;
  endfunction
  function automatic logic cur_fin(input bit big);
    return big ? fin_b : fin_s;
  endfunction
  task automatic set_ready(input bit big, input logic v);
    if (big) bif.gray_ready = v; else sif.gray_ready = v;
  endtask

  function automatic bit is_border(input int w, input int h, input int a);
    int x, y;
    x = a % w; y = a / w;
    return (x == 0) || (x == w - 1) || (y == 0) || (y == h - 1);
  endfunction

  // Reference LBP computed directly on the 2-D image.
  function automatic logic [7:0] model(input int w, input int h, input bit m,
                                       input logic [7:0] t, input int a);
    int x, y, th, k;
    logic [7:0] c;
    int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    x = a % w; y = a / w;
    if (is_border(w, h, a)) return 8'h00;
    th = int'(img[a]) + (m ? int'(t) : 0);
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k = (y + dy[i]) * w + (x + dx[i]);
      if (int'(img[k]) >= th) c[i] = 1'b1;
    end
    return c;
  endfunction

  task automatic fill_img(input int pat, input int w, input int n);
    for (int i = 0; i < n; i++) begin
      case (pat)
        0: img[i] = 8'h55;
        1: img[i] = 8'(i % w);
        2: img[i] = 8'($urandom_range(0, 255));
        default: img[i] = (i == 5 * w + 5) ? 8'hFF : 8'h00;
      endcase
    end
  endtask

  // Reset, start one frame, optionally stall, and wait (bounded) for finish.
  task automatic run_frame(input bit big, input bit m, input logic [7:0] t,
                           input bit stall, input bit flip,
                           output int lat_fin, output int lat_first, output int stall_tot);
    int n, t0c, cyc, reqs, d;
    bit seen;
    n = big ? BW * BH : SW * SH;
    for (int i = 0; i < 16384; i++) begin
      wcnt[i] = 0;
      mem[i]  = 8'hxx;
    end
    order_err = 0;
    last_addr = -1;
    @(negedge clk);
    reset = 1'b0;
    set_ready(1'b1, 1'b0);
    set_ready(1'b0, 1'b0);
    if (big) begin mode_b = m; thr_b = t; end
    else     begin mode_s = m; thr_s = t; end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_ready(big, 1'b1);
    lat_fin = -1; lat_first = -1; stall_tot = 0;
    seen = 1'b0; reqs = 0; cyc = 0; t0c = 0;
    while (cyc < 40000 && lat_fin < 0) begin
      @(posedge clk); #1; cyc++;
      if (cur_req(big)) begin
        reqs++;
        if (!seen) begin
          seen = 1'b1;
          t0c  = cyc;
          if (flip) begin
            if (big) begin mode_b = ~mode_b; thr_b = ~thr_b; end
            else     begin mode_s = ~mode_s; thr_s = ~thr_s; end
          end
        end
      end
      if (seen && lat_first < 0 && cur_valid(big)) lat_first = cyc - t0c;
      if (cur_fin(big)) begin
        lat_fin = seen ? cyc - t0c : 0;
      end else if (stall && seen && reqs < n && $urandom_range(0, 11) == 0) begin
        d = $urandom_range(1, 5);
        set_ready(big, 1'b0);
        stall_tot += d;
        repeat (d) begin
          @(posedge clk); #1; cyc++;
        end
        set_ready(big, 1'b1);
      end
    end
    set_ready(big, 1'b0);
  endtask

  task automatic check_frame(input string tag, input bit big, input bit use_model,
                             input bit m, input logic [7:0] t,
                             input logic [7:0] ei, input logic [7:0] eb);
    int w, h, n, bad_w, bad_d, first_bad;
    logic [7:0] exp;
    w = big ? BW : SW; h = big ? BH : SH; n = w * h;
    bad_w = 0; bad_d = 0; first_bad = -1;
    for (int a = 0; a < n; a++) begin
      if (wcnt[a] != 1) bad_w++;
      exp = use_model ? model(w, h, m, t, a) : (is_border(w, h, a) ? eb : ei);
      if (mem[a] !== exp) begin
        bad_d++;
        if (first_bad < 0) first_bad = a;
      end
    end
    check({tag, " addresses not written once"}, bad_w, 0);
    check({tag, " address order violations"}, order_err, 0);
    check($sformatf("%s bad codes (first at %0d)", tag, first_bad), bad_d, 0);
  endtask

  typedef struct {
    bit         big;
    int         pat;
    bit         m;
    logic [7:0] t;
    bit         stall;
    bit         flip;
    bit         use_model;
    logic [7:0] ei;
    logic [7:0] eb;
  } vec_t;

  initial begin
    vec_t vt [6];
    int   lat_fin, lat_first, stall_tot, w, n, cyc;
    bit   found, fin_seen;
    int         sp_a [9] = '{45, 36, 37, 38, 44, 46, 52, 53, 54};
    logic [7:0] sp_e [9] = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    vt[0] = '{1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00}; // 128x128 flat, std
    vt[1] = '{1'b0, 0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // flat, thr=1
    vt[2] = '{1'b0, 1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; // gradient, no wrap
    vt[3] = '{1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD6, 8'h00}; // gradient, mode flipped after start
    vt[4] = '{1'b0, 2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00}; // random, stalls
    vt[5] = '{1'b0, 2, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00}; // random thr, stalls

    reset = 1'b0;
    bif.gray_ready = 1'b0; sif.gray_ready = 1'b0;
    mode_b = 1'b0; mode_s = 1'b0; thr_b = 8'h00; thr_s = 8'h00;
    for (int i = 0; i < 16384; i++) img[i] = 8'h00;

    #1;
    check("reset big outputs", int'(bif.gray_req) + int'(bif.gray_addr) + int'(bif.lbp_valid) +
          int'(bif.lbp_addr) + int'(bif.lbp_data) + int'(fin_b), 0);
    check("reset small outputs", int'(sif.gray_req) + int'(sif.gray_addr) + int'(sif.lbp_valid) +
          int'(sif.lbp_addr) + int'(sif.lbp_data) + int'(fin_s), 0);

    for (int v = 0; v < 6; v++) begin
      w = vt[v].big ? BW : SW;
      n = vt[v].big ? BW * BH : SW * SH;
      fill_img(vt[v].pat, w, n);
      run_frame(vt[v].big, vt[v].m, vt[v].t, vt[v].stall, vt[v].flip, lat_fin, lat_first, stall_tot);
      check($sformatf("vec%0d finish latency", v), lat_fin, n + w + 3 + stall_tot);
      if (!vt[v].stall) check($sformatf("vec%0d first valid latency", v), lat_first, w + 3);
      check_frame($sformatf("vec%0d", v), vt[v].big, vt[v].use_model, vt[v].m, vt[v].t,
                  vt[v].ei, vt[v].eb);
    end

    // Single bright pixel at (5,5) on 8x8 with thr=1: exposes each weight.
    fill_img(3, SW, SW * SH);
    run_frame(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, lat_fin, lat_first, stall_tot);
    check("spot finish latency", lat_fin, SW * SH + SW + 3);
    for (int i = 0; i < 9; i++) check($sformatf("spot addr %0d", sp_a[i]), int'(mem[sp_a[i]]), int'(sp_e[i]));
    check_frame("spot", 1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00);

    // Reset while the big instance is mid-frame, then a fresh frame.
    fill_img(2, BW, BW * BH);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; mode_b = 1'b0; thr_b = 8'h00;
    @(negedge clk); bif.gray_ready = 1'b1;
    found = 1'b0; fin_seen = 1'b0; cyc = 0;
    while (!found && cyc < 12000) begin
      @(posedge clk); #1; cyc++;
      if (fin_b) fin_seen = 1'b1;
      if (bif.gray_req && bif.gray_addr == 14'd9000) found = 1'b1;
    end
    check("reached pixel 9000", int'(found), 1);
    check("finish before mid-frame reset", int'(fin_seen), 0);
    #2 reset = 1'b0;
    #1;
    check("mid reset gray_req", int'(bif.gray_req), 0);
    check("mid reset gray_addr", int'(bif.gray_addr), 0);
    check("mid reset lbp port", int'(bif.lbp_valid) + int'(bif.lbp_addr) + int'(bif.lbp_data), 0);
    check("mid reset finish", int'(fin_b), 0);
    fill_img(2, BW, BW * BH);
    run_frame(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, lat_fin, lat_first, stall_tot);
    check("restart finish latency", lat_fin, BW * BH + BW + 3);
    check("restart first valid latency", lat_first, BW + 3);
    check_frame("restart", 1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
